// File: rtl/palette_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : palette_load_ctrl
// Purpose  : Copies a block of 1..512 bytes from GPU RAM into the text or
//            graphics palette RAM via the mixer's palette host port.
//            Transfers can optionally wait for a vsync rising edge first, and
//            CPU palette writes always take priority over engine writes.
// Ports    : clk, rst_n                   - clock, async active-low reset
//            cfg_wr/cfg_addr/cfg_data     - config register write port
//            vs_in                        - vertical sync (active-high)
//            mem_rd_req/mem_addr          - GPU RAM read request / address
//            mem_rd_ack/mem_rd_data       - GPU RAM one-cycle ack / data
//            host_wrena_in/addr_in/data_in- CPU palette write path
//            pal_wrena/pal_addr/pal_data  - registered palette write out
//            busy, done                   - status (done is a 1-cycle pulse)
// Revision : 1.0 - initial release
// ============================================================================
module palette_load_ctrl #(
    parameter logic [19:0] TXT_PALETTE_ADDR = 20'h04000,
    parameter logic [19:0] GFX_PALETTE_ADDR = 20'h04200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_wr,
    input  logic [1:0]  cfg_addr,
    input  logic [7:0]  cfg_data,
    input  logic        vs_in,
    output logic        mem_rd_req,
    output logic [15:0] mem_addr,
    input  logic        mem_rd_ack,
    input  logic [7:0]  mem_rd_data,
    input  logic        host_wrena_in,
    input  logic [19:0] host_addr_in,
    input  logic [7:0]  host_data_in,
    output logic        pal_wrena,
    output logic [19:0] pal_addr,
    output logic [7:0]  pal_data,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_VS = 3'd1,
        S_READ    = 3'd2,
        S_WRITE   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    // Config registers (visible to the CPU)
    logic [15:0] r_src_cfg;
    logic [8:0]  r_len_cfg;
    logic        r_dest_cfg;
    logic        r_wait_cfg;

    // Working copies used by the running transfer
    logic [15:0] r_wsrc;
    logic [8:0]  r_len;
    logic        r_dest;
    logic [8:0]  r_off;
    logic [7:0]  r_data;

    logic        r_vs;
    logic        r_vs_low_seen;
    logic        r_pal_wrena;
    logic [19:0] r_pal_addr;
    logic [7:0]  r_pal_data;

    logic        w_cfg3;
    logic        w_start;
    logic        w_abort;
    logic        w_eng_wr;
    logic        w_last;
    logic        w_vs_edge;
    logic [19:0] w_base;
    logic [19:0] w_eng_addr;
    logic        w_unused;

    assign w_cfg3     = cfg_wr && (cfg_addr == 2'd3);
    assign w_start    = w_cfg3 && cfg_data[2];
    assign w_abort    = w_cfg3 && cfg_data[4];
    // Engine write only goes out on a cycle the CPU leaves the port free
    assign w_eng_wr   = (r_state == S_WRITE) && !host_wrena_in && !w_abort;
    assign w_last     = (r_off == r_len);
    // Only an edge whose low phase was observed inside WAIT_VS counts, so a
    // vsync level that was already high on entry is ignored.
    assign w_vs_edge  = (r_state == S_WAIT_VS) && r_vs && r_vs_low_seen;
    assign w_base     = r_dest ? GFX_PALETTE_ADDR : TXT_PALETTE_ADDR;
    assign w_eng_addr = w_base + {11'd0, r_off};
    assign w_unused   = &{1'b0, cfg_data[7:5]};

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next     = r_state;
        busy       = (r_state != S_IDLE);
        done       = (r_state == S_DONE);
        mem_rd_req = (r_state == S_READ);
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next = cfg_data[3] ? S_WAIT_VS : S_READ;
                end
            end
            S_WAIT_VS: begin
                if (w_vs_edge) begin
                    w_next = S_READ;
                end
            end
            S_READ: begin
                if (mem_rd_ack) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (w_eng_wr) begin
                    w_next = w_last ? S_DONE : S_READ;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        // Abort overrides everything, including an ack in the same cycle
        if (w_abort && (r_state != S_IDLE) && (r_state != S_DONE)) begin
            w_next = S_DONE;
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src_cfg     <= 16'd0;
            r_len_cfg     <= 9'd0;
            r_dest_cfg    <= 1'b0;
            r_wait_cfg    <= 1'b0;
            r_wsrc        <= 16'd0;
            r_len         <= 9'd0;
            r_dest        <= 1'b0;
            r_off         <= 9'd0;
            r_data        <= 8'd0;
            r_vs          <= 1'b0;
            r_vs_low_seen <= 1'b0;
            r_pal_wrena   <= 1'b0;
            r_pal_addr    <= 20'd0;
            r_pal_data    <= 8'd0;
        end else begin
            if (cfg_wr) begin
                case (cfg_addr)
                    2'd0: r_src_cfg[7:0]  <= cfg_data;
                    2'd1: r_src_cfg[15:8] <= cfg_data;
                    2'd2: r_len_cfg[7:0]  <= cfg_data;
                    default: begin
                        r_len_cfg[8] <= cfg_data[0];
                        r_dest_cfg   <= cfg_data[1];
                        r_wait_cfg   <= cfg_data[3];
                    end
                endcase
            end

            // The start write itself carries dest/wait_vs/len_m1[8], so take
            // those bits straight from the bus rather than the old register.
            if ((r_state == S_IDLE) && w_start) begin
                r_wsrc <= r_src_cfg;
                r_len  <= {cfg_data[0], r_len_cfg[7:0]};
                r_dest <= cfg_data[1];
                r_off  <= 9'd0;
            end

            if ((r_state == S_READ) && mem_rd_ack && !w_abort) begin
                r_data <= mem_rd_data;
            end

            if (w_eng_wr) begin
                r_wsrc <= r_wsrc + 16'd1;
                r_off  <= r_off + 9'd1;
            end

            r_vs          <= vs_in;
            r_vs_low_seen <= (r_state == S_WAIT_VS) ? (r_vs_low_seen | ~r_vs) : 1'b0;

            r_pal_wrena <= host_wrena_in | w_eng_wr;
            if (host_wrena_in) begin
                r_pal_addr <= host_addr_in;
                r_pal_data <= host_data_in;
            end else if (w_eng_wr) begin
                r_pal_addr <= w_eng_addr;
                r_pal_data <= r_data;
            end
        end
    end

    assign mem_addr  = r_wsrc;
    assign pal_wrena = r_pal_wrena;
    assign pal_addr  = r_pal_addr;
    assign pal_data  = r_pal_data;

endmodule
`default_nettype wire

// File: tb/tb_palette_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_palette_load_ctrl
// Purpose  : Self-checking bench for palette_load_ctrl. A GPU RAM model
//            answers read requests; expected palette writes are queued as
//            stimulus is issued and compared against the observed writes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_palette_load_ctrl;

    localparam logic [19:0] C_TXT = 20'h04000;
    localparam logic [19:0] C_GFX = 20'h04200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_wr;
    logic [1:0]  cfg_addr;
    logic [7:0]  cfg_data;
    logic        vs_in;
    logic        mem_rd_req;
    logic [15:0] mem_addr;
    logic        mem_rd_ack;
    logic [7:0]  mem_rd_data;
    logic        host_wrena_in;
    logic [19:0] host_addr_in;
    logic [7:0]  host_data_in;
    logic        pal_wrena;
    logic [19:0] pal_addr;
    logic [7:0]  pal_data;
    logic        busy;
    logic        done;

    logic [7:0]  mem [0:65535];
    logic [27:0] exp_q[$];
    logic [27:0] obs_q[$];
    logic [15:0] rd_q[$];
    int          n_pass = 0;
    int          n_total = 0;
    int          done_cnt = 0;
    int          lat_cnt = 0;
    bit          ack_en = 1'b1;

    always #5 clk = ~clk;

    palette_load_ctrl #(
        .TXT_PALETTE_ADDR(C_TXT),
        .GFX_PALETTE_ADDR(C_GFX)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_wr        (cfg_wr),
        .cfg_addr      (cfg_addr),
        .cfg_data      (cfg_data),
        .vs_in         (vs_in),
        .mem_rd_req    (mem_rd_req),
        .mem_addr      (mem_addr),
        .mem_rd_ack    (mem_rd_ack),
        .mem_rd_data   (mem_rd_data),
        .host_wrena_in (host_wrena_in),
        .host_addr_in  (host_addr_in),
        .host_data_in  (host_data_in),
        .pal_wrena     (pal_wrena),
        .pal_addr      (pal_addr),
        .pal_data      (pal_data),
        .busy          (busy),
        .done          (done)
    );

    // GPU RAM model: acknowledges a pending request after a short latency
    initial begin
        mem_rd_ack  = 1'b0;
        mem_rd_data = 8'd0;
        forever begin
            @(negedge clk);
            if (mem_rd_ack) begin
                mem_rd_ack = 1'b0;
            end else if (mem_rd_req && ack_en) begin
                if (lat_cnt >= 2) begin
                    mem_rd_ack  = 1'b1;
                    mem_rd_data = mem[mem_addr];
                    rd_q.push_back(mem_addr);
                    lat_cnt     = 0;
                end else begin
                    lat_cnt++;
                end
            end else begin
                lat_cnt = 0;
            end
        end
    end

    // Output monitor: records palette writes and done pulses
    initial begin
        forever begin
            @(negedge clk);
            if (pal_wrena) obs_q.push_back({pal_addr, pal_data});
            if (done) done_cnt++;
        end
    end

    task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        cfg_wr = 1'b1; cfg_addr = a; cfg_data = d;
        @(negedge clk);
        cfg_wr = 1'b0;
    endtask

    task automatic start_xfer(input logic [15:0] src, input logic [8:0] len,
                              input logic dest, input logic wv);
        cfg_write(2'd0, src[7:0]);
        cfg_write(2'd1, src[15:8]);
        cfg_write(2'd2, len[7:0]);
        cfg_write(2'd3, {3'b000, 1'b0, wv, 1'b1, dest, len[8]});
    endtask

    task automatic push_engine(input logic [15:0] src, input int nbytes, input logic dest);
        logic [15:0] a;
        logic [19:0] b;
        b = dest ? C_GFX : C_TXT;
        for (int i = 0; i < nbytes; i++) begin
            a = src + 16'(i);
            exp_q.push_back({b + 20'(i), mem[a]});
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int d0;
        d0 = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt != d0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic clear_q();
        exp_q.delete(); obs_q.delete(); rd_q.delete();
    endtask

    task automatic test_reset();
        bit act;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL rst_done: got %b expected 0", done); else n_pass++;
        n_total++; if (mem_rd_req !== 1'b0) $display("FAIL rst_req: got %b expected 0", mem_rd_req); else n_pass++;
        n_total++; if ({pal_wrena, pal_addr, pal_data, mem_addr} !== 45'd0)
            $display("FAIL rst_outs: got %h expected 0", {pal_wrena, pal_addr, pal_data, mem_addr});
        else n_pass++;
        rst_n = 1'b1;
        act = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (mem_rd_req || pal_wrena || busy) act = 1'b1;
        end
        n_total++; if (act !== 1'b0) $display("FAIL rst_idle_activity: got %b expected 0", act); else n_pass++;
        clear_q();
    endtask

    task automatic test_basic();
        bit ok;
        logic [27:0] e, o;
        clear_q();
        mem[16'h1000] = 8'hA0; mem[16'h1001] = 8'hA1;
        mem[16'h1002] = 8'hA2; mem[16'h1003] = 8'hA3;
        push_engine(16'h1000, 4, 1'b0);
        start_xfer(16'h1000, 9'd3, 1'b0, 1'b0);
        wait_done(200, ok);
        n_total++; if (ok !== 1'b1) $display("FAIL basic_done: got %b expected 1", ok); else n_pass++;
        n_total++; if (done_cnt !== 1) $display("FAIL basic_done_count: got %0d expected 1", done_cnt); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL basic_busy_after: got %b expected 0", busy); else n_pass++;
        n_total++; if (obs_q.size() !== exp_q.size())
            $display("FAIL basic_wr_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_total++; if (o !== e) $display("FAIL basic_wr: got %h expected %h", o, e); else n_pass++;
        end
    endtask

    task automatic test_wait_vs();
        bit ok, seen;
        logic [27:0] e, o;
        clear_q();
        vs_in = 1'b1;
        repeat (3) @(negedge clk);
        push_engine(16'h2000, 1, 1'b0);
        start_xfer(16'h2000, 9'd0, 1'b0, 1'b1);
        seen = 1'b0;
        repeat (12) begin @(negedge clk); if (mem_rd_req) seen = 1'b1; end
        n_total++; if (seen !== 1'b0) $display("FAIL vs_high_no_req: got %b expected 0", seen); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL vs_busy_waiting: got %b expected 1", busy); else n_pass++;
        vs_in = 1'b0;
        repeat (5) begin @(negedge clk); if (mem_rd_req) seen = 1'b1; end
        n_total++; if (seen !== 1'b0) $display("FAIL vs_low_no_req: got %b expected 0", seen); else n_pass++;
        vs_in = 1'b1;
        wait_done(100, ok);
        n_total++; if (ok !== 1'b1) $display("FAIL vs_done: got %b expected 1", ok); else n_pass++;
        n_total++; if (obs_q.size() !== 1) $display("FAIL vs_wr_count: got %0d expected 1", obs_q.size()); else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_total++; if (o !== e) $display("FAIL vs_wr: got %h expected %h", o, e); else n_pass++;
        end
        vs_in = 1'b0;
    endtask

    task automatic test_host_priority();
        bit ok, got;
        logic [27:0] e, o;
        clear_q();
        start_xfer(16'h2100, 9'd1, 1'b0, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (mem_rd_ack) begin got = 1'b1; break; end
        end
        n_total++; if (got !== 1'b1) $display("FAIL host_ack_seen: got %b expected 1", got); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            host_wrena_in = 1'b1;
            host_addr_in  = 20'h04010 + 20'(k);
            host_data_in  = 8'h11 * 8'(k + 1);
            exp_q.push_back({host_addr_in, host_data_in});
        end
        @(negedge clk);
        host_wrena_in = 1'b0;
        push_engine(16'h2100, 2, 1'b0);
        wait_done(200, ok);
        n_total++; if (ok !== 1'b1) $display("FAIL host_done: got %b expected 1", ok); else n_pass++;
        n_total++; if (obs_q.size() !== 5) $display("FAIL host_wr_count: got %0d expected 5", obs_q.size()); else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_total++; if (o !== e) $display("FAIL host_wr_order: got %h expected %h", o, e); else n_pass++;
        end
    endtask

    task automatic test_src_wrap();
        bit ok;
        logic [27:0] e, o;
        logic [15:0] ea;
        clear_q();
        push_engine(16'hFFFE, 4, 1'b1);
        start_xfer(16'hFFFE, 9'd3, 1'b1, 1'b0);
        wait_done(200, ok);
        n_total++; if (ok !== 1'b1) $display("FAIL wrap_done: got %b expected 1", ok); else n_pass++;
        n_total++; if (rd_q.size() !== 4) $display("FAIL wrap_rd_count: got %0d expected 4", rd_q.size()); else n_pass++;
        ea = 16'hFFFE;
        while (rd_q.size() > 0) begin
            n_total++;
            if (rd_q[0] !== ea) $display("FAIL wrap_mem_addr: got %h expected %h", rd_q[0], ea); else n_pass++;
            void'(rd_q.pop_front());
            ea = ea + 16'd1;
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_total++; if (o !== e) $display("FAIL wrap_wr: got %h expected %h", o, e); else n_pass++;
        end
    endtask

    task automatic test_abort();
        bit ok;
        int n, c, d0;
        logic [27:0] e, o;
        clear_q();
        push_engine(16'h3000, 2, 1'b0);
        start_xfer(16'h3000, 9'd7, 1'b0, 1'b0);
        n = 0;
        for (int i = 0; i < 200 && n < 2; i++) begin
            @(posedge clk); #1;
            if (pal_wrena) n++;
        end
        d0 = done_cnt;
        cfg_write(2'd3, 8'h10);
        c = 0;
        while (busy && c < 3) begin @(negedge clk); c++; end
        n_total++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy); else n_pass++;
        repeat (6) @(negedge clk);
        n_total++; if (done_cnt - d0 !== 1) $display("FAIL abort_done_pulses: got %0d expected 1", done_cnt - d0); else n_pass++;
        n_total++; if (obs_q.size() !== 2) $display("FAIL abort_wr_count: got %0d expected 2", obs_q.size()); else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_total++; if (o !== e) $display("FAIL abort_wr: got %h expected %h", o, e); else n_pass++;
        end
        clear_q();
        push_engine(16'h3100, 2, 1'b1);
        start_xfer(16'h3100, 9'd1, 1'b1, 1'b0);
        wait_done(200, ok);
        n_total++; if (ok !== 1'b1) $display("FAIL restart_done: got %b expected 1", ok); else n_pass++;
        n_total++; if (obs_q.size() !== 2) $display("FAIL restart_wr_count: got %0d expected 2", obs_q.size()); else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_total++; if (o !== e) $display("FAIL restart_wr: got %h expected %h", o, e); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_read();
        bit ok, act;
        logic [27:0] e, o;
        clear_q();
        ack_en = 1'b0;
        start_xfer(16'h4000, 9'd3, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        n_total++; if (mem_rd_req !== 1'b1) $display("FAIL midrd_req_before: got %b expected 1", mem_rd_req); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (mem_rd_req !== 1'b0) $display("FAIL midrd_req_async: got %b expected 0", mem_rd_req); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL midrd_busy_async: got %b expected 0", busy); else n_pass++;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        ack_en = 1'b1;
        clear_q();
        act = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (mem_rd_req || pal_wrena) act = 1'b1;
        end
        n_total++; if (act !== 1'b0) $display("FAIL midrd_no_activity: got %b expected 0", act); else n_pass++;
        // Config regs were cleared, so a bare start reads one byte from 0x0000
        push_engine(16'h0000, 1, 1'b0);
        cfg_write(2'd3, 8'h04);
        wait_done(100, ok);
        n_total++; if (ok !== 1'b1) $display("FAIL midrd_restart_done: got %b expected 1", ok); else n_pass++;
        n_total++; if (rd_q.size() !== 1) $display("FAIL midrd_rd_count: got %0d expected 1", rd_q.size());
        else begin
            if (rd_q[0] !== 16'h0000) $display("FAIL midrd_rd_addr: got %h expected 0000", rd_q[0]);
            else n_pass++;
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_total++; if (o !== e) $display("FAIL midrd_wr: got %h expected %h", o, e); else n_pass++;
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h3C;
        end
        rst_n         = 1'b0;
        cfg_wr        = 1'b0;
        cfg_addr      = 2'd0;
        cfg_data      = 8'd0;
        vs_in         = 1'b0;
        host_wrena_in = 1'b0;
        host_addr_in  = 20'd0;
        host_data_in  = 8'd0;

        test_reset();
        test_basic();
        test_wait_vs();
        test_host_priority();
        test_src_wrap();
        test_abort();
        test_reset_mid_read();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
